ps2_key_event_decoder: RTL
==========================

// Module: ps2_key_event_decoder
// PURPOSE
//  PS/2 keyboard receiver plus letter decoder with a queued event interface. Synchronises kbdclk/kbddat,
//  deserialises 11-bit frames and checks parity/stop. Tracks F0 (break) and E0 (extended) prefixes,
//  maps scancodes to letter indices, pushes {letter, release} events into a FIFO with valid/ready pop.
//  Sits between the PS/2 pins and game logic; replaces direct per-cycle keycode-to-letter mapping.
// PARAMETERS
//  FIFO_DEPTH   4       event FIFO entries, power of 2, >=2
//  LETTER_W     5       evt_letter width, >=4; index zero-extended
//  TIMEOUT_CYC  100000  clk cycles with no kbdclk falling edge before a partial frame is abandoned
//  SYNC_STAGES  2       flip-flop synchroniser depth on kbdclk and kbddat, >=2
// PORTS
//  clk            in   1         system clock
//  rst_n          in   1         asynchronous active-low reset
//  kbdclk         in   1         PS/2 clock, asynchronous to clk
//  kbddat         in   1         PS/2 data, asynchronous to clk
//  evt_valid      out  1         FIFO head valid
//  evt_ready      in   1         consumer accepts head; pop when evt_valid & evt_ready
//  evt_letter     out  LETTER_W  head letter index 0..15
//  evt_release    out  1         head is a key release (1) or press (0)
//  frame_err      out  1         1-cycle pulse: start/parity/stop error or timeout
//  fifo_overflow  out  1         1-cycle pulse: event dropped because FIFO full
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE, bit counter, timeout counter, prefix flags, FIFO pointers/count
//    cleared; all outputs 0. A frame cut by reset is discarded; resync via start-bit check/timeout.
//  - Bits are sampled on the clk cycle where the synchronised kbdclk shows 1->0.
//  - FSM: IDLE --edge,dat=0--> DATA; IDLE --edge,dat=1--> IDLE + frame_err.
//    DATA: 8 edges, LSB first --> PARITY --edge--> STOP --edge--> IDLE.
//    Frame good iff ^{data,parity}==1 and stop==1; else frame_err, byte dropped, prefix flags cleared.
//  - Timeout: in DATA/PARITY/STOP, counter counts clk since last edge; reaching TIMEOUT_CYC
//    forces IDLE, frame_err pulse, prefixes cleared. Counter held at 0 in IDLE.
//  - Byte decode (cycle after good STOP sample):
//    F0 -> set brk; E0 -> set ext; AA,FA,EE,FE,00,FF -> clear both, no event.
//    Other byte with ext=1 -> discarded, flags cleared. Otherwise table lookup, flags cleared after:
//    1C=0 32=1 21=2 23=3 24=4 2B=5 34=6 33=7 3B=8 4B=9 31=10 44=11 4D=12 2D=13 1B=14 35=15;
//    hit -> push {index, brk}; miss -> no event.
//  - Latency: event written the cycle after the STOP sample; evt_valid high the following cycle if
//    FIFO was empty (FWFT; head outputs registered, stable while evt_valid & !evt_ready).
//  - FIFO: push when full and no pop -> event dropped, fifo_overflow pulse, contents unchanged.
//    Push and pop same cycle when full -> both happen, count unchanged, no overflow.
//    Push and pop same cycle when empty -> impossible (no head); push lands, valid next cycle.
//    Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  - evt_letter/evt_release hold last popped values when evt_valid=0 (0 after reset).
// CONFIGURATION
//  KBD_TYPEMATIC_FILTER_EN defined: 16-bit held mask; press of a held index suppressed (no push);
//    press sets bit, release clears bit and always pushes. Mask cleared on reset only.
//    Bit set/clear happens at decode time even if the push overflows.
//  Not defined: no mask; every press byte, incl. typematic auto-repeat, pushes an event.
// TESTING
//  1 frame 0x1C, parity 0, stop 1, evt_ready=1 -> one event letter=0 release=0; frame_err stays 0.
//  2 frames F0,1C -> exactly one event letter=0 release=1; no event for F0.
//  3 frame 0x32 with parity 1 (wrong) -> frame_err 1-cycle pulse, no event; next good 0x32 -> letter=1.
//  4 FIFO_DEPTH=4, evt_ready=0, presses 1C,32,21,23,24 -> 4 queued, fifo_overflow on 5th;
//    then evt_ready=1 -> pops letters 0,1,2,3 in order, evt_valid falls after 4th.
//  5 start+4 data bits then kbdclk idle TIMEOUT_CYC+2 cycles -> one frame_err; then frame 0x21 -> letter=2.
//  6 E0,1C -> no event. 1C,1C,1C,F0,1C -> filter_EN: 2 events (press 0, release 0);
//    without: 4 events (3 press, 1 release). Assert rst_n=0 mid-frame -> outputs 0 immediately.

Source files
------------

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: PS/2 frame receiver, letter decoder and FWFT event FIFO.
// Optional feature: define KBD_TYPEMATIC_FILTER_EN to suppress auto-repeat presses of held keys.
`default_nettype none

module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LETTER_W    = 5,
    parameter int TIMEOUT_CYC = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kbdclk,
    input  logic                kbddat,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [LETTER_W-1:0] evt_letter,
    output logic                evt_release,
    output logic                frame_err,
    output logic                fifo_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_t;

    // Synchronisers idle high so reset release never looks like a falling kbdclk edge.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], kbdclk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], kbddat};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    rx_state_t        state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             par;
    logic [TO_W-1:0]  to_cnt;
    logic             byte_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (state == S_IDLE) begin
                to_cnt <= '0;
                if (fall) begin
                    if (!bit_in) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    S_DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par   <= bit_in;
                        state <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if ((^{shreg, par}) && bit_in) byte_rdy  <= 1'b1;
                        else                           frame_err <= 1'b1;
                    end
                endcase
            end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                state     <= S_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // Returns {hit, index}.
    function automatic logic [4:0] lookup(input logic [7:0] b);
        case (b)
            8'h1C: lookup = 5'h10;  8'h32: lookup = 5'h11;
            8'h21: lookup = 5'h12;  8'h23: lookup = 5'h13;
            8'h24: lookup = 5'h14;  8'h2B: lookup = 5'h15;
            8'h34: lookup = 5'h16;  8'h33: lookup = 5'h17;
            8'h3B: lookup = 5'h18;  8'h4B: lookup = 5'h19;
            8'h31: lookup = 5'h1A;  8'h44: lookup = 5'h1B;
            8'h4D: lookup = 5'h1C;  8'h2D: lookup = 5'h1D;
            8'h1B: lookup = 5'h1E;  8'h35: lookup = 5'h1F;
            default: lookup = 5'h00;
        endcase
    endfunction

    logic       brk;
    logic       ext;
    logic       is_f0;
    logic       is_e0;
    logic [4:0] lk;
    logic       key_hit;
    logic       push;
    logic [LETTER_W:0] push_data;

    assign is_f0     = (shreg == 8'hF0);
    assign is_e0     = (shreg == 8'hE0);
    assign lk        = lookup(shreg);
    assign key_hit   = byte_rdy && !is_f0 && !is_e0 && !ext && lk[4];
    assign push_data = {brk, LETTER_W'(lk[3:0])};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (frame_err) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (byte_rdy) begin
            if (is_f0) begin
                brk <= 1'b1;
            end else if (is_e0) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [15:0] held;

    // Mask tracks decoded keys even when the resulting push is dropped by a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (key_hit) begin
            held[lk[3:0]] <= !brk;
        end
    end

    assign push = key_hit && (brk || !held[lk[3:0]]);
`else
    assign push = key_hit;
`endif

    logic [LETTER_W:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic [PTR_W-1:0]  rd_next;
    logic [LETTER_W:0] head_next;

    assign pop           = evt_valid && evt_ready;
    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok       = push && (!full || pop);
    assign cnt_after_pop = count - CNT_W'(pop);
    assign rd_next       = rd_ptr + PTR_W'(pop);

    // Head registers load straight from the push when the queue would otherwise be empty.
    always_comb begin
        head_next = {evt_release, evt_letter};
        if (cnt_after_pop != '0) head_next = mem[rd_next];
        else if (push_ok)        head_next = push_data;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            evt_valid     <= 1'b0;
            evt_letter    <= '0;
            evt_release   <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            rd_ptr        <= rd_next;
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            count         <= cnt_after_pop + CNT_W'(push_ok);
            evt_valid     <= (cnt_after_pop != '0) || push_ok;
            {evt_release, evt_letter} <= head_next;
            fifo_overflow <= push && full && !pop;
        end
    end

endmodule

`default_nettype wire
